// File: rtl/clock_handler_pkg.sv
// Shared constants for the UART baud clock handler: code map, baud table,
// divisor arithmetic and the power-on code.
package clock_handler_pkg;

  localparam int NUM_CODES = 7;

  typedef enum logic [3:0] {
    BAUD_2400   = 4'd0,
    BAUD_4800   = 4'd1,
    BAUD_9600   = 4'd2,
    BAUD_19200  = 4'd3,
    BAUD_38400  = 4'd4,
    BAUD_57600  = 4'd5,
    BAUD_115200 = 4'd6
  } baud_code_e;

  localparam logic [3:0] DEFAULT_CODE = BAUD_9600;

  localparam int BAUD_TABLE [NUM_CODES] = '{
    2400, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // Rounded to nearest: adding half of the 16x rate before dividing.
  function automatic int baud_divisor(input int clk_freq,
                                      input int baud);
    return (clk_freq + 8 * baud) / (16 * baud);
  endfunction

  function automatic logic code_is_valid(input logic [3:0] code);
    return code < 4'(NUM_CODES);
  endfunction

endpackage

// File: rtl/baud_divider.sv
// Free-running 0..divisor-1 counter producing a one-cycle 16x baud enable.
// A restart forces the count back to zero for a clean rate change.
module baud_divider
  import clock_handler_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic             wrap;

  assign wrap = (cnt_q == divisor - DIV_W'(1));
  assign tick = wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (restart || wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clock_handler_module.sv
// Baud-select command decode and the active-code register.
// Readback on data_out/data_out_valid exists only with CLOCK_HANDLER_READBACK_EN.
module clock_handler_module
  import clock_handler_pkg::*;
#(
  parameter int         CLK_FREQ    = 100_000_000,
  parameter logic [3:0] MODULE_ADDR = 4'h1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] address,
  input  logic [3:0] data,
  input  logic       valid,
  output logic       ack,
  output logic [3:0] data_out,
  output logic       data_out_valid,
  output logic       clk_16bd
);

  localparam int MAX_DIV = baud_divisor(CLK_FREQ, BAUD_TABLE[0]);
  localparam int DIV_W   = $clog2(MAX_DIV + 1);

  logic [DIV_W-1:0] div_tab [NUM_CODES];
  logic [DIV_W-1:0] divisor;
  logic             valid_q;
  logic             ack_q;
  logic [3:0]       code_q;
  logic [3:0]       code_d;
  logic             rise;
  logic             hit;
  logic             restart;

  for (genvar g = 0; g < NUM_CODES; g++) begin : g_div
    assign div_tab[g] = DIV_W'(baud_divisor(CLK_FREQ, BAUD_TABLE[g]));
  end

  always_comb begin
    divisor = div_tab[DEFAULT_CODE];
    for (int i = 0; i < NUM_CODES; i++) begin
      if (code_q == 4'(i)) divisor = div_tab[i];
    end
  end

  assign rise    = valid & ~valid_q;
  assign hit     = rise && (address == MODULE_ADDR);
  assign restart = hit && code_is_valid(data);
  assign code_d  = restart ? data : code_q;
  assign ack     = ack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      code_q  <= DEFAULT_CODE;
    end else begin
      valid_q <= valid;
      ack_q   <= hit;
      code_q  <= code_d;
    end
  end

`ifdef CLOCK_HANDLER_READBACK_EN
  logic [3:0] dout_q;
  logic       dov_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= DEFAULT_CODE;
      dov_q  <= 1'b0;
    end else begin
      dov_q <= hit;
      if (hit) dout_q <= code_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dov_q;
`else
  assign data_out       = 4'h0;
  assign data_out_valid = 1'b0;
`endif

  baud_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .divisor (divisor),
    .restart (restart),
    .tick    (clk_16bd)
  );

endmodule

// File: tb/tb_clock_handler_module.sv
// Randomized bench for clock_handler_module against a timeline model:
// a pulse is due whenever the cycles since the last restart hit divisor-1.
module tb_clock_handler_module;

`ifdef CLOCK_HANDLER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] address = '0;
  logic [3:0] data = '0;
  logic       valid = 1'b0;
  logic       ack;
  logic [3:0] data_out;
  logic       data_out_valid;
  logic       clk_16bd;

  int vectors = 0;
  int errors  = 0;

  int div_tab [7] = '{2604, 1302, 651, 326, 163, 109, 54};

  // reference model state
  int         cyc = 0;
  int         m_restart = 0;
  logic [3:0] m_code = 4'd2;
  logic [3:0] m_dout = 4'd2;
  logic       m_prev = 1'b0;
  logic       m_ack = 1'b0;

  // monitor bookkeeping
  int tcyc = 0;
  int pulses = 0;
  int last_pulse = 0;
  int last_spacing = 0;
  int ack_count = 0;
  int dov_count = 0;

  clock_handler_module #(
    .CLK_FREQ    (100_000_000),
    .MODULE_ADDR (4'h1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .address        (address),
    .data           (data),
    .valid          (valid),
    .ack            (ack),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .clk_16bd       (clk_16bd)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rb(input logic [3:0] c);
    return RB ? c : 4'h0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc       <= 0;
      m_restart <= 0;
      m_code    <= 4'd2;
      m_dout    <= 4'd2;
      m_prev    <= 1'b0;
      m_ack     <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      m_prev <= valid;
      m_ack  <= valid && !m_prev && address == 4'h1;
      if (valid && !m_prev && address == 4'h1) begin
        if (data <= 4'd6) begin
          m_code    <= data;
          m_dout    <= data;
          m_restart <= cyc + 1;
        end else begin
          m_dout <= m_code;
        end
      end
    end
  end

  always @(posedge clk) tcyc <= tcyc + 1;

  always @(negedge clk) begin
    int  d;
    logic exp_tick;
    d = div_tab[m_code];
    exp_tick = rst && (((cyc - m_restart) % d) == d - 1);
    vectors += 4;
    if (clk_16bd !== exp_tick) begin
      errors++;
      $display("FAIL tick t=%0d got %b exp %b", tcyc, clk_16bd, exp_tick);
    end
    if (ack !== m_ack) begin
      errors++;
      $display("FAIL ack t=%0d got %b exp %b", tcyc, ack, m_ack);
    end
    if (data_out_valid !== (RB & m_ack)) begin
      errors++;
      $display("FAIL dov t=%0d got %b exp %b", tcyc, data_out_valid,
               RB & m_ack);
    end
    if (data_out !== rb(m_dout)) begin
      errors++;
      $display("FAIL dout t=%0d got %h exp %h", tcyc, data_out, rb(m_dout));
    end
    if (!rst) begin
      pulses = 0;
    end else if (clk_16bd === 1'b1) begin
      if (pulses > 0) last_spacing = tcyc - last_pulse;
      last_pulse = tcyc;
      pulses++;
    end
    if (ack === 1'b1) ack_count++;
    if (data_out_valid === 1'b1) dov_count++;
  end

  task automatic cmd(input logic [3:0] a, input logic [3:0] d,
                     input int hold);
    @(negedge clk);
    #1;
    address = a;
    data    = d;
    valid   = 1'b1;
    repeat (hold) @(negedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int limit, output bit ok);
    int target;
    target = pulses + n;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (pulses >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (ack !== 1'b0 || data_out_valid !== 1'b0 ||
        data_out !== rb(4'h2) || clk_16bd !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got %b %b %h %b exp 0 0 %h 0",
               ack, data_out_valid, data_out, clk_16bd, rb(4'h2));
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (700) @(negedge clk);
    #1;
    vectors++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL reset_700 got %0d pulses exp 1", pulses);
    end
    wait_pulses(1, 3000, ok);
    vectors++;
    if (!ok || last_spacing != 651) begin
      errors++;
      $display("FAIL reset_spacing got %0d exp 651 ok=%b", last_spacing, ok);
    end
  endtask

  task automatic test_write();
    int a0, v0;
    bit ok;
    a0 = ack_count;
    v0 = dov_count;
    cmd(4'h1, 4'h2, 2);
    repeat (4) @(negedge clk);
    #1;
    vectors += 3;
    if (ack_count - a0 != 1) begin
      errors++;
      $display("FAIL write_ack got %0d exp 1", ack_count - a0);
    end
    if (dov_count - v0 != (RB ? 1 : 0)) begin
      errors++;
      $display("FAIL write_dov got %0d exp %0d", dov_count - v0, RB);
    end
    if (data_out !== rb(4'h2)) begin
      errors++;
      $display("FAIL write_dout got %h exp %h", data_out, rb(4'h2));
    end
    wait_pulses(2, 3000, ok);
    vectors++;
    if (!ok || last_spacing != 651) begin
      errors++;
      $display("FAIL write_spacing got %0d exp 651 ok=%b", last_spacing, ok);
    end
  endtask

  task automatic test_wrong_addr();
    int a0;
    bit ok;
    logic [3:0] a;
    a0 = ack_count;
    a = 4'($urandom_range(15, 2));
    cmd(a, 4'h1, 1);
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (ack_count != a0) begin
      errors++;
      $display("FAIL wrong_addr_ack got %0d exp 0", ack_count - a0);
    end
    wait_pulses(2, 3000, ok);
    vectors++;
    if (!ok || last_spacing != 651) begin
      errors++;
      $display("FAIL wrong_addr_spacing got %0d exp 651", last_spacing);
    end
  endtask

  task automatic test_invalid();
    int a0;
    bit ok;
    a0 = ack_count;
    cmd(4'h1, 4'($urandom_range(15, 7)), 1);
    repeat (4) @(negedge clk);
    #1;
    vectors += 2;
    if (ack_count - a0 != 1) begin
      errors++;
      $display("FAIL invalid_ack got %0d exp 1", ack_count - a0);
    end
    if (data_out !== rb(4'h2)) begin
      errors++;
      $display("FAIL invalid_dout got %h exp %h", data_out, rb(4'h2));
    end
    wait_pulses(2, 3000, ok);
    vectors++;
    if (!ok || last_spacing != 651) begin
      errors++;
      $display("FAIL invalid_spacing got %0d exp 651", last_spacing);
    end
  endtask

  task automatic test_rate_change();
    int a0;
    bit ok;
    a0 = ack_count;
    cmd(4'h1, 4'h1, 1);
    repeat (2) @(negedge clk);
    #1;
    vectors += 2;
    if (ack_count - a0 != 1) begin
      errors++;
      $display("FAIL rate_ack got %0d exp 1", ack_count - a0);
    end
    if (data_out !== rb(4'h1)) begin
      errors++;
      $display("FAIL rate_dout got %h exp %h", data_out, rb(4'h1));
    end
    wait_pulses(2, 5000, ok);
    vectors++;
    if (!ok || last_spacing != 1302) begin
      errors++;
      $display("FAIL rate_spacing got %0d exp 1302", last_spacing);
    end
  endtask

  task automatic test_reset_mid();
    int a0;
    bit ok;
    cmd(4'h1, 4'h5, 1);
    rst = 1'b0;
    #1;
    vectors++;
    if (ack !== 1'b0 || data_out_valid !== 1'b0 ||
        data_out !== rb(4'h2)) begin
      errors++;
      $display("FAIL midreset got %b %b %h exp 0 0 %h",
               ack, data_out_valid, data_out, rb(4'h2));
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_pulses(2, 3000, ok);
    vectors++;
    if (!ok || last_spacing != 651) begin
      errors++;
      $display("FAIL midreset_spacing got %0d exp 651", last_spacing);
    end
    a0 = ack_count;
    cmd(4'h1, 4'hF, 1);
    repeat (2) @(negedge clk);
    #1;
    vectors += 2;
    if (ack_count - a0 != 1) begin
      errors++;
      $display("FAIL midreset_ack got %0d exp 1", ack_count - a0);
    end
    if (data_out !== rb(4'h2)) begin
      errors++;
      $display("FAIL midreset_dout got %h exp %h", data_out, rb(4'h2));
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    bit ok;
    a0 = ack_count;
    cmd(4'h1, 4'h3, 1);
    cmd(4'h1, 4'h4, 1);
    repeat (2) @(negedge clk);
    #1;
    vectors += 2;
    if (ack_count - a0 != 2) begin
      errors++;
      $display("FAIL b2b_ack got %0d exp 2", ack_count - a0);
    end
    if (data_out !== rb(4'h4)) begin
      errors++;
      $display("FAIL b2b_dout got %h exp %h", data_out, rb(4'h4));
    end
    wait_pulses(2, 1000, ok);
    vectors++;
    if (!ok || last_spacing != 163) begin
      errors++;
      $display("FAIL b2b_spacing got %0d exp 163", last_spacing);
    end
  endtask

  task automatic test_random();
    int a0, exp_acks;
    logic [3:0] a;
    a0 = ack_count;
    exp_acks = 0;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(1, 0) == 1) ? 4'h1 : 4'($urandom_range(15, 0));
      if (a == 4'h1) exp_acks++;
      cmd(a, 4'($urandom_range(15, 0)), $urandom_range(3, 1));
      repeat ($urandom_range(300, 1)) @(negedge clk);
    end
    #1;
    vectors++;
    if (ack_count - a0 != exp_acks) begin
      errors++;
      $display("FAIL random_acks got %0d exp %0d", ack_count - a0, exp_acks);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_invalid();
    test_rate_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/clock_handler_module.md
CLOCK_HANDLER_MODULE -- requirements
Module: clock_handler_module

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter MODULE_ADDR, default 4'h1, meaning the bus address this block responds to.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port address, input, 4 bits: command target address.
REQ-006 SHALL have port data, input, 4 bits: command payload, the baud-select code.
REQ-007 SHALL have port valid, input, 1 bit: command strobe; it may be held high for multiple cycles.
REQ-008 SHALL have port ack, output, 1 bit: one-cycle pulse acknowledging a command addressed to this block.
REQ-009 SHALL have port data_out, output, 4 bits: readback of the active baud-select code.
REQ-010 SHALL have port data_out_valid, output, 1 bit: one-cycle qualifier for data_out.
REQ-011 SHALL have port clk_16bd, output, 1 bit: one-cycle enable pulse at 16x the selected baud rate.
REQ-012 Port order SHALL be: clk, rst, address, data, valid, ack, data_out, data_out_valid, clk_16bd.

Function
REQ-013 Baud codes SHALL map as follows: 0=2400, 1=4800, 2=9600, 3=19200, 4=38400, 5=57600, 6=115200; codes 7-15 are invalid.
REQ-014 The divisor SHALL be (CLK_FREQ + 8*baud) / (16*baud), using integer math and computed at elaboration.
REQ-015 At 100 MHz the divisors SHALL be 2604, 1302, 651, 326, 163, 109 and 54 for codes 0-6.
REQ-016 A command SHALL be accepted only on the rising edge of valid, detected as valid=1 with the registered previous valid=0; holding valid high SHALL NOT retrigger.
REQ-017 An accepted command with address==MODULE_ADDR SHALL assert ack for exactly one cycle, in the cycle after detection.
REQ-018 A command with any other address SHALL be ignored entirely: no ack, no state change.
REQ-019 A valid code SHALL update the active code at the detection edge.
REQ-020 On a code update the divider counter SHALL restart from 0, so the first new-rate clk_16bd pulse comes divisor cycles later.
REQ-021 An invalid code SHALL still be acked, SHALL leave the active code and counter unchanged, and SHALL produce no glitch on clk_16bd.
REQ-022 data_out_valid SHALL pulse together with ack; data_out SHALL carry the active code after the update (the old code if the command was invalid).
REQ-023 data_out SHALL hold its value between pulses.
REQ-024 The counter SHALL count 0..divisor-1 and wrap; clk_16bd SHALL be high only in the cycle where the counter equals divisor-1.
REQ-025 Rewriting the same code SHALL be acked and SHALL restart the counter.

Reset
REQ-026 While rst=0, the active code SHALL be 2 (9600 baud), the counter SHALL be 0, and the previous-valid register SHALL be 0.
REQ-027 While rst=0, the outputs SHALL be ack=0, data_out_valid=0, data_out=4'h2 and clk_16bd=0.
REQ-028 Reset asserted mid-operation SHALL discard any pending ack and revert to 9600 baud immediately.

Configuration
REQ-029 With macro CLOCK_HANDLER_READBACK_EN defined, data_out and data_out_valid SHALL behave per REQ-022 and REQ-023.
REQ-030 Without CLOCK_HANDLER_READBACK_EN, data_out SHALL be tied to 4'h0 and data_out_valid to 0; ack and all other behaviour SHALL be unchanged.

Structure
REQ-031 Package clock_handler_pkg SHALL hold the baud code constants, the baud-rate table, the divisor function, and the default code (2).
REQ-032 A sub-module baud_divider SHALL contain the counter and the clk_16bd generation.
REQ-033 baud_divider SHALL take a divisor input and a restart input.
REQ-034 The top level SHALL contain only command decode and registers.

Verification
REQ-035 Reset: release rst, run 700 cycles -> clk_16bd pulses exactly every 651 cycles; data_out=2.
REQ-036 Write: address=1, data=2, valid held 2 cycles -> exactly one ack pulse and one data_out_valid pulse with data_out=2; pulse spacing 651.
REQ-037 Wrong address: address=9, data=1, valid pulse -> no ack; spacing stays 651.
REQ-038 Invalid code: address=1, data=15 -> one ack; data_out=2; spacing unchanged.
REQ-039 Rate change: address=1, data=1 -> ack with data_out=1; spacing 1302.
REQ-040 Reset after that change: rst low for 2 cycles -> spacing returns to 651; then address=1, data=15 -> ack; data_out=2.
